// File: rtl/dsp_sig_array.sv
// Array of N_CH pipelined DSP sites driven by a bounded LFSR burst.
// All P outputs are folded into one 32-bit signature, reported once per run.

module dsp_sig_site (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [29:0] a,
  input  logic [17:0] b,
  input  logic [47:0] c,
  input  logic [24:0] d,
  output logic [47:0] p
);

  logic [29:0]        a_q;
  logic [17:0]        b_q;
  logic [47:0]        c_q;
  logic [47:0]        c2_q;
  logic [24:0]        d_q;
  logic [47:0]        m_q;
  logic [47:0]        p_q;
  logic signed [24:0] ad;
  logic signed [42:0] ad_x;
  logic signed [42:0] b_x;
  logic signed [42:0] mult;
  logic               unused_a_hi;

  // Pre-adder uses the low 25 bits of A; C is delayed one extra stage so it meets M.
  assign ad          = $signed(d_q) + $signed(a_q[24:0]);
  assign ad_x        = $signed({{18{ad[24]}}, ad});
  assign b_x         = $signed({{25{b_q[17]}}, b_q});
  assign mult        = ad_x * b_x;
  assign unused_a_hi = ^a_q[29:25];
  assign p           = p_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q  <= '0;
      b_q  <= '0;
      c_q  <= '0;
      c2_q <= '0;
      d_q  <= '0;
      m_q  <= '0;
      p_q  <= '0;
    end else begin
      a_q  <= a;
      b_q  <= b;
      c_q  <= c;
      d_q  <= d;
      c2_q <= c_q;
      m_q  <= {{5{mult[42]}}, mult};
      p_q  <= m_q + c2_q;
    end
  end

endmodule

module dsp_sig_array #(
  parameter int          N_CH  = 5,
  parameter int          DIN_W = 176,
  parameter int          N_CYC = 256,
  parameter int          PIPE  = 3,
  parameter logic [31:0] SEED  = 32'h1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [DIN_W-1:0] din,
  output logic             busy,
  output logic             done,
  output logic [31:0]      dout
);

  localparam logic [31:0] SEED_EFF   = (SEED == 32'h0) ? 32'h1 : SEED;
  localparam logic [31:0] LFSR_TAPS  = 32'h8020_0003;
  localparam logic [15:0] LAST_RUN   = 16'(N_CYC - 1);
  localparam logic [15:0] LAST_DRAIN = 16'(PIPE - 1);
  localparam logic [15:0] PIPE_SAT   = 16'(PIPE);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic [15:0] cnt_q;
  logic [15:0] cnt_total_q;
  logic [31:0] lfsr_q;
  logic [31:0] sig_q;
  logic [31:0] sig_d;
  logic [31:0] dout_q;
  logic [31:0] fold_all;
  logic [1:0]  mode_q;
  logic        run_active;
  logic        sample;
  logic [24:0] d_drive;
  logic [47:0] p_all [N_CH];

  assign run_active = (state_q == RUN);
  assign sample     = ((state_q == RUN) || (state_q == DRAIN)) && (cnt_total_q == PIPE_SAT);
  assign busy       = run_active || (state_q == DRAIN);
  assign done       = (state_q == DONE);
  assign dout       = dout_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (cnt_q == LAST_RUN) state_d = DRAIN;
      DRAIN:   if (cnt_q == LAST_DRAIN) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    d_drive = '0;
    if (run_active) begin
      case (mode_q)
        2'd0:    d_drive = din[120:96];
        2'd1:    d_drive = '0;
        2'd2:    d_drive = 25'd1;
        default: d_drive = lfsr_q[24:0];
      endcase
    end
  end

  // Each site sees the LFSR rotated by its index; operands are zero outside RUN.
  for (genvar g = 0; g < N_CH; g++) begin : g_site
    logic [31:0] r;
    logic [29:0] a;
    logic [17:0] b;
    logic [47:0] c;

    assign r = (lfsr_q << g) | (lfsr_q >> (32 - g));
    assign a = run_active ? (din[29:0] ^ r[29:0]) : '0;
    assign b = run_active ? (din[47:30] ^ r[17:0]) : '0;
    assign c = run_active ? (din[95:48] ^ {r[15:0], r}) : '0;

    dsp_sig_site u_site (
      .clk   (clk),
      .rst_n (rst_n),
      .a     (a),
      .b     (b),
      .c     (c),
      .d     (d_drive),
      .p     (p_all[g])
    );
  end

  if (DIN_W > 121) begin : g_din_spare
    logic unused_din;
    assign unused_din = ^din[DIN_W-1:121];
  end

  always_comb begin
    fold_all = '0;
    for (int i = 0; i < N_CH; i++) begin
      fold_all = fold_all ^ p_all[i][31:0] ^ {16'h0, p_all[i][47:32]};
    end
  end

  assign sig_d = sample ? ({sig_q[30:0], sig_q[31]} ^ fold_all) : sig_q;

  // dout is loaded on the edge into DONE so it is already valid while done is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      cnt_total_q <= '0;
      lfsr_q      <= SEED_EFF;
      sig_q       <= '0;
      mode_q      <= '0;
      dout_q      <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (start) begin
            mode_q      <= mode;
            sig_q       <= '0;
            cnt_q       <= '0;
            cnt_total_q <= '0;
          end
        end
        RUN: begin
          lfsr_q <= {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 32'h0);
          sig_q  <= sig_d;
          cnt_q  <= (cnt_q == LAST_RUN) ? 16'd0 : cnt_q + 16'd1;
          if (cnt_total_q != PIPE_SAT) cnt_total_q <= cnt_total_q + 16'd1;
        end
        DRAIN: begin
          sig_q <= sig_d;
          cnt_q <= cnt_q + 16'd1;
          if (cnt_total_q != PIPE_SAT) cnt_total_q <= cnt_total_q + 16'd1;
          if (cnt_q == LAST_DRAIN) dout_q <= sig_d;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dsp_sig_array.sv
// Scoreboard bench for dsp_sig_array: a five-site array (SEED=1) and a
// single-site array (SEED=0), both with a 4-cycle burst.

module tb_dsp_sig_array;

  localparam int NCYC = 4;
  localparam int NPIPE = 3;

  logic         clk;
  logic         rst_n;
  logic         start_m, start_a;
  logic [1:0]   mode_m, mode_a;
  logic [175:0] din_m, din_a;
  logic         busy_m, busy_a, done_m, done_a;
  logic [31:0]  dout_m, dout_a;

  logic [31:0]  exp_m[$];
  logic [31:0]  exp_a[$];
  logic [31:0]  lf_m, lf_a;
  int           n_cmp;
  int           n_bad;

  dsp_sig_array #(.N_CH(5), .DIN_W(176), .N_CYC(NCYC), .PIPE(NPIPE), .SEED(32'h1)) u_main (
    .clk(clk), .rst_n(rst_n), .start(start_m), .mode(mode_m), .din(din_m),
    .busy(busy_m), .done(done_m), .dout(dout_m)
  );

  dsp_sig_array #(.N_CH(1), .DIN_W(176), .N_CYC(NCYC), .PIPE(NPIPE), .SEED(32'h0)) u_alt (
    .clk(clk), .rst_n(rst_n), .start(start_a), .mode(mode_a), .din(din_a),
    .busy(busy_a), .done(done_a), .dout(dout_a)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: signature of one run, with the LFSR state carried across runs.
  function automatic logic [31:0] model_sig(input int nch, input logic [1:0] md,
                                            input logic [175:0] dv, input logic [31:0] lf_in,
                                            output logic [31:0] lf_out);
    logic [31:0] l, r, s, fx;
    logic [29:0] a;
    logic [17:0] b;
    logic [47:0] c, p, m;
    logic [24:0] d;
    logic signed [24:0] ad;
    l = lf_in;
    s = '0;
    for (int k = 0; k < NCYC; k++) begin
      fx = '0;
      for (int i = 0; i < nch; i++) begin
        r = l;
        for (int j = 0; j < i; j++) r = {r[30:0], r[31]};
        a = dv[29:0] ^ r[29:0];
        b = dv[47:30] ^ r[17:0];
        c = dv[95:48] ^ {r[15:0], r};
        case (md)
          2'd0:    d = dv[120:96];
          2'd1:    d = 25'd0;
          2'd2:    d = 25'd1;
          default: d = l[24:0];
        endcase
        ad = $signed(d) + $signed(a[24:0]);
        m = $signed({{23{ad[24]}}, ad}) * $signed({{30{b[17]}}, b});
        p = m + c;
        fx = fx ^ p[31:0] ^ {16'h0, p[47:32]};
      end
      s = {s[30:0], s[31]} ^ fx;
      l = {1'b0, l[31:1]} ^ (l[0] ? 32'h8020_0003 : 32'h0);
    end
    lf_out = l;
    return s;
  endfunction

  task automatic check_output(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  // Monitor: pops the scoreboard whenever either array reports done.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && done_m === 1'b1) begin
      if (exp_m.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("[TB] FAIL dout_main: unexpected done, dout %h", dout_m);
      end else begin
        check_output("dout_main", dout_m, exp_m.pop_front());
      end
    end
    if (rst_n === 1'b1 && done_a === 1'b1) begin
      if (exp_a.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("[TB] FAIL dout_alt: unexpected done, dout %h", dout_a);
      end else begin
        check_output("dout_alt", dout_a, exp_a.pop_front());
      end
    end
  end

  task automatic apply_stimulus(input bit alt, input logic [1:0] md, input logic [175:0] dv,
                                input bit disturb);
    int  busy_n;
    int  lat;
    bit  seen;
    @(negedge clk);
    if (alt) begin
      exp_a.push_back(model_sig(1, md, dv, lf_a, lf_a));
      mode_a  = md;
      din_a   = dv;
      start_a = 1'b1;
    end else begin
      exp_m.push_back(model_sig(5, md, dv, lf_m, lf_m));
      mode_m  = md;
      din_m   = dv;
      start_m = 1'b1;
    end
    busy_n = 0;
    lat    = 0;
    seen   = 1'b0;
    for (int cyc = 1; cyc <= 40 && !seen; cyc++) begin
      @(negedge clk);
      if (cyc == 1) begin
        start_m = 1'b0;
        start_a = 1'b0;
      end
      if (disturb && cyc == 2) begin
        mode_m  = 2'd3;
        start_m = 1'b1;
      end
      if (disturb && cyc == 3) start_m = 1'b0;
      lat = cyc;
      if (alt ? busy_a : busy_m) busy_n++;
      if (alt ? done_a : done_m) seen = 1'b1;
    end
    if (!seen) begin
      n_cmp++;
      n_bad++;
      $display("[TB] FAIL done_timeout: no done after %0d cycles, required %0d", lat, NCYC + NPIPE + 1);
    end else begin
      check_output("done_latency", 32'(lat), 32'(NCYC + NPIPE + 1));
      check_output("busy_cycles", 32'(busy_n), 32'(NCYC + NPIPE));
      @(negedge clk);
      check_output("done_pulse", {31'h0, alt ? done_a : done_m}, 32'h0);
    end
  endtask

  initial begin
    n_cmp   = 0;
    n_bad   = 0;
    rst_n   = 1'b0;
    start_m = 1'b0;
    start_a = 1'b0;
    mode_m  = 2'd0;
    mode_a  = 2'd0;
    din_m   = '0;
    din_a   = '0;
    lf_m    = 32'h1;
    lf_a    = 32'h1;
    repeat (3) @(negedge clk);
    check_output("rst_busy_main", {31'h0, busy_m}, 32'h0);
    check_output("rst_done_main", {31'h0, done_m}, 32'h0);
    check_output("rst_dout_main", dout_m, 32'h0);
    check_output("rst_busy_alt", {31'h0, busy_a}, 32'h0);
    check_output("rst_done_alt", {31'h0, done_a}, 32'h0);
    check_output("rst_dout_alt", dout_a, 32'h0);
    rst_n = 1'b1;

    apply_stimulus(1'b0, 2'd1, '0, 1'b0);
    apply_stimulus(1'b0, 2'd1, '0, 1'b0);
    apply_stimulus(1'b0, 2'd1, '0, 1'b0);
    apply_stimulus(1'b0, 2'd0, 176'({6{32'hA5C3_1E7F}}), 1'b1);
    apply_stimulus(1'b0, 2'd2, 176'({11{16'h3C96}}), 1'b0);
    apply_stimulus(1'b0, 2'd3, 176'({22{8'h5A}}), 1'b0);

    // Abort a run at cnt=2 of RUN.
    @(negedge clk);
    mode_m  = 2'd1;
    din_m   = '0;
    start_m = 1'b1;
    @(negedge clk);
    start_m = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_output("abort_busy", {31'h0, busy_m}, 32'h0);
    check_output("abort_dout", dout_m, 32'h0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_output("abort_no_done", {31'h0, done_m}, 32'h0);
    end
    rst_n = 1'b1;
    lf_m  = 32'h1;
    lf_a  = 32'h1;
    apply_stimulus(1'b0, 2'd1, '0, 1'b0);

    apply_stimulus(1'b1, 2'd2, '1, 1'b0);
    apply_stimulus(1'b1, 2'd1, '1, 1'b0);
    apply_stimulus(1'b1, 2'd1, '0, 1'b0);

    repeat (4) @(negedge clk);
    check_output("queue_main_empty", 32'(exp_m.size()), 32'h0);
    check_output("queue_alt_empty", 32'(exp_a.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: simulation still running, required finish");
    $fatal(1, "[TB] timeout");
  end

endmodule
